// File: rtl/wormhole_allocator_if.sv
// ---------------------------------------------------------------------------
// wormhole_allocator_if
// Bundles the per-output-port allocation signals of the wormhole allocator.
//   req_i       [4:0] per-requester flit present (0 local, 1 south, 2 west,
//                     3 east, 4 north)
//   tail_i      [4:0] presented flit is the last of its packet
//   credit_up_i       downstream freed one buffer slot this cycle
//   grant_o     [4:0] registered one-hot owner, or all zero
//   send_o            one flit from the owner transfers this cycle
//   credit_o    [2:0] current downstream credit count
//   busy_o            port is locked to an owner
//   timeout_o         one-cycle pulse on watchdog release
// Modports: master drives requests/credits, slave is the allocator.
// ---------------------------------------------------------------------------
interface wormhole_allocator_if;
   logic [4:0] req_i;
   logic [4:0] tail_i;
   logic       credit_up_i;
   logic [4:0] grant_o;
   logic       send_o;
   logic [2:0] credit_o;
   logic       busy_o;
   logic       timeout_o;

   modport master (
      output req_i, tail_i, credit_up_i,
      input  grant_o, send_o, credit_o, busy_o, timeout_o
   );

   modport slave (
      input  req_i, tail_i, credit_up_i,
      output grant_o, send_o, credit_o, busy_o, timeout_o
   );
endinterface

// File: rtl/wormhole_allocator.sv
// ---------------------------------------------------------------------------
// wormhole_allocator
// Round-robin wormhole allocator for one router output port with
// credit-based downstream flow control. A winner is locked onto the port
// until its tail flit transfers; credits gate every flit transfer.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - wormhole_allocator_if.slave (req/tail/credit_up in,
//          grant/send/credit/busy/timeout out)
// Parameter CREDIT_MAX (1..7): downstream buffer depth in flits.
// Optional feature macro ALLOC_WATCHDOG_EN: releases a lock whose owner
// has stopped requesting for 15 consecutive cycles and pulses timeout_o.
// ---------------------------------------------------------------------------
module wormhole_allocator #(
   parameter int CREDIT_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   wormhole_allocator_if.slave  bus
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [2:0] CREDIT_FULL = 3'(CREDIT_MAX);

   state_t     state_q, state_d;
   logic [4:0] grant_q, grant_d;
   logic [2:0] owner_q, owner_d;
   logic [2:0] last_owner_q, last_owner_d;
   logic [2:0] credit_q, credit_d;
   logic       owner_req;
   logic       send;
   logic       tail_done;
   logic       release_wd;

   // Round-robin pick: the first requester at offset 1..5 above last owner.
   // Scanning offsets downward lets the smallest offset overwrite the rest.
   function automatic logic [2:0] rr_pick(input logic [4:0] req,
                                          input logic [2:0] last);
      logic [2:0] pick;
      int         idx;
      pick = 3'd0;
      for (int k = 5; k >= 1; k--) begin
         idx = (int'(last) + k) % 5;
         if (req[idx]) pick = 3'(idx);
      end
      return pick;
   endfunction

   assign owner_req = bus.req_i[owner_q];
   assign send      = (state_q == LOCKED) && owner_req && (credit_q != 3'd0);
   assign tail_done = send && bus.tail_i[owner_q];

   // Credit return and consumption cancel; a return at full depth is dropped.
   always_comb begin
      credit_d = credit_q;
      if (send && !bus.credit_up_i)
         credit_d = credit_q - 3'd1;
      else if (bus.credit_up_i && !send && (credit_q < CREDIT_FULL))
         credit_d = credit_q + 3'd1;
   end

`ifdef ALLOC_WATCHDOG_EN
   logic [3:0] wd_cnt_q, wd_cnt_d;
   logic       timeout_q;

   // Counts consecutive locked cycles in which the owner presents nothing;
   // the lock is released on the cycle the count reaches 15.
   always_comb begin
      wd_cnt_d   = 4'd0;
      release_wd = 1'b0;
      if ((state_q == LOCKED) && !owner_req) begin
         wd_cnt_d   = wd_cnt_q + 4'd1;
         release_wd = (wd_cnt_d == 4'd15);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_q  <= 4'd0;
         timeout_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= release_wd;
      end
   end

   assign bus.timeout_o = timeout_q;
`else
   assign release_wd    = 1'b0;
   assign bus.timeout_o = 1'b0;
`endif

   // Next-state: arbitrate in IDLE, hold the lock until tail or watchdog.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      case (state_q)
         IDLE: begin
            if ((|bus.req_i) && (credit_q != 3'd0)) begin
               owner_d = rr_pick(bus.req_i, last_owner_q);
               grant_d = 5'b00001 << owner_d;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (tail_done || release_wd) begin
               state_d      = IDLE;
               grant_d      = 5'b00000;
               last_owner_d = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 5'b00000;
         owner_q      <= 3'd0;
         last_owner_q <= 3'd4;
         credit_q     <= CREDIT_FULL;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         credit_q     <= credit_d;
      end
   end

   assign bus.grant_o  = grant_q;
   assign bus.send_o   = send;
   assign bus.credit_o = credit_q;
   assign bus.busy_o   = (state_q == LOCKED);

endmodule

// File: doc/wormhole_allocator.md
WORMHOLE_ALLOCATOR -- requirements
Module: wormhole_allocator

Interface
REQ-001 The block SHALL have parameter CREDIT_MAX, default 4, giving the downstream buffer depth in flits; legal range 1..7.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_i, input, 5 bits: per-requester flit present for this output port; bit 0 local, 1 south, 2 west, 3 east, 4 north.
REQ-005 The block SHALL have port tail_i, input, 5 bits: the flit presented by requester n is the last flit of its packet; sampled only with req_i[n].
REQ-006 The block SHALL have port credit_up_i, input, 1 bit: downstream freed one buffer slot this cycle.
REQ-007 The block SHALL have port grant_o, output, 5 bits: registered one-hot owner of the output port, or all zero.
REQ-008 The block SHALL have port send_o, output, 1 bit: combinational; one flit from the owner transfers this cycle.
REQ-009 The block SHALL have port credit_o, output, 3 bits: current downstream credit count.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high while state is LOCKED.
REQ-011 The block SHALL have port timeout_o, output, 1 bit: one-cycle pulse on watchdog release.

Function
REQ-012 The FSM SHALL have two states, IDLE and LOCKED; busy_o SHALL be 1 exactly in LOCKED.
REQ-013 In IDLE with any req_i bit set and credit_o != 0, the FSM SHALL choose the winner round-robin, searching from last_owner+1 mod 5 upward.
REQ-014 The winner SHALL appear on grant_o and the FSM SHALL enter LOCKED on the next edge; this is a 1-cycle arbitration latency, with no send in the arbitration cycle.
REQ-015 In IDLE with credit_o == 0, no grant SHALL be issued regardless of req_i.
REQ-016 In LOCKED, send_o SHALL equal req_i[owner] AND (credit_o != 0); it SHALL be 0 in IDLE.
REQ-017 In LOCKED, requests from non-owners SHALL be ignored; there is no preemption.
REQ-018 On send_o with tail_i[owner] = 1, the FSM SHALL do all of: go to IDLE next edge; clear grant_o; set last_owner to the owner.
REQ-019 A single-flit packet (head with tail set) SHALL occupy LOCKED for exactly one transfer cycle.
REQ-020 Credit update: next credit = credit + credit_up_i - send_o; simultaneous up and send SHALL leave credit unchanged.
REQ-021 credit_o SHALL never exceed CREDIT_MAX; credit_up_i at CREDIT_MAX without a send SHALL be ignored.
REQ-022 send_o SHALL never assert at credit 0, so credit never underflows.
REQ-023 After release, re-arbitration SHALL occur in the IDLE cycle that follows; back-to-back packets therefore have a 1-cycle gap.

Reset
REQ-024 On rst at a rising edge, the block SHALL set state to IDLE and grant_o to 0.
REQ-025 On rst, credit_o SHALL be CREDIT_MAX, last_owner SHALL be 4 (so local has first priority), and the watchdog count SHALL be 0.
REQ-026 On rst, timeout_o SHALL be 0 and busy_o SHALL be 0.
REQ-027 A reset mid-packet SHALL drop the lock unconditionally; rst SHALL dominate all other inputs in the same cycle.

Configuration
REQ-028 With macro ALLOC_WATCHDOG_EN defined, a 4-bit counter SHALL count consecutive LOCKED cycles with req_i[owner] = 0.
REQ-029 With ALLOC_WATCHDOG_EN defined, the counter SHALL clear on any cycle with req_i[owner] = 1 and on IDLE.
REQ-030 With ALLOC_WATCHDOG_EN defined, at count 15 the FSM SHALL force IDLE, clear grant_o, set last_owner to the owner, and pulse timeout_o for one cycle.
REQ-031 Without ALLOC_WATCHDOG_EN, the counter SHALL be absent, timeout_o SHALL be tied to 0, and the lock SHALL be held until the tail transfers.

Verification
REQ-032 Scenario: after reset, req_i = 5'b10001 with 3-flit packets -> local (bit 0) granted first; north granted after local's tail; grant_o = 5'b00001 then 5'b10000.
REQ-033 Scenario: credit_o = 4, owner sends 6 flits with no credit_up_i -> send_o high for 4 cycles, then low with credit_o = 0; one credit_up_i -> exactly one more send.
REQ-034 Scenario: credit_o = 2, credit_up_i and send_o together for 3 cycles -> credit_o stays 2; credit_up_i at 4 without send -> stays 4.
REQ-035 Scenario: all five requesting continuously with single-flit packets -> grants rotate 0,1,2,3,4,0 with one IDLE cycle between each.
REQ-036 Scenario: rst asserted during flit 2 of a 4-flit packet -> next cycle grant_o = 0, busy_o = 0, credit_o = CREDIT_MAX.
REQ-037 Scenario (ALLOC_WATCHDOG_EN): owner drops req_i mid-packet -> timeout_o pulses 15 cycles later, grant_o = 0, and the next requester is granted.
